// File: rtl/riscv_dmem_mmio_if.sv
// Memory-stage bus plus output byte stream between the core and the data memory.
interface riscv_dmem_mmio_if #(
  parameter int LED_W = 8
);
  logic             MemWrite;
  logic [31:0]      ALUResult;
  logic [31:0]      WriteData;
  logic [31:0]      ReadData;
  logic [LED_W-1:0] leds;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output MemWrite, ALUResult, WriteData, out_ready,
    input  ReadData, leds, out_data, out_valid
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, out_ready,
    output ReadData, leds, out_data, out_valid
  );
endinterface

// File: rtl/riscv_dmem_mmio.sv
// Data memory with MMIO page: word RAM, LED register, cycle counter and
// an output byte FIFO drained over a valid/ready stream.
module riscv_dmem_mmio #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  riscv_dmem_mmio_if.slave   bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      mem [RAM_WORDS];
  logic [LED_W-1:0] leds_q, leds_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [7:0]       buf_q [FIFO_DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic        is_mmio;
  logic [15:0] off;
  logic        ram_we, wr_led, wr_cyc, wr_tx, wr_stat;
  logic        full, empty, pop, push_ok;
  logic [31:0] status;
  logic [31:0] rdata;

  assign is_mmio = (bus.ALUResult[31:16] == 16'hFFFF);
  assign off     = bus.ALUResult[15:0];
  assign ram_we  = bus.MemWrite & ~is_mmio;
  assign wr_led  = bus.MemWrite & is_mmio & (off == 16'h0000);
  assign wr_cyc  = bus.MemWrite & is_mmio & (off == 16'h0004);
  assign wr_tx   = bus.MemWrite & is_mmio & (off == 16'h0008);
  assign wr_stat = bus.MemWrite & is_mmio & (off == 16'h000C);

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = ~empty & bus.out_ready;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push_ok = wr_tx & (~full | pop);

  assign status  = {16'b0, 8'(cnt_q), 5'b0, ovf_q, full, empty};

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[bus.ALUResult[AW+1:2]] <= bus.WriteData;
  end

  // Next-state for registers, counter and FIFO bookkeeping.
  always_comb begin
    leds_d = leds_q;
    cyc_d  = cyc_q + 32'd1;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (wr_led) leds_d = bus.WriteData[LED_W-1:0];
    if (wr_cyc) cyc_d  = bus.WriteData;
    if (pop)     head_d = head_q + PW'(1);
    if (push_ok) tail_d = tail_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Overflow wins over a same-cycle clear so no drop goes unreported.
    if (wr_stat) ovf_d = 1'b0;
    if (wr_tx & full & ~pop) ovf_d = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q <= '0;
      cyc_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      cyc_q  <= cyc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage; cleared on reset so out_data is never X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) buf_q[i] <= 8'h00;
    end else if (push_ok) begin
      buf_q[tail_q] <= bus.WriteData[7:0];
    end
  end

  // Combinational load mux keeps single-cycle memory-stage timing.
  always_comb begin
    rdata = 32'h0;
    if (!is_mmio) begin
      rdata = mem[bus.ALUResult[AW+1:2]];
    end else begin
      case (off)
        16'h0000: rdata = 32'(leds_q);
        16'h0004: rdata = cyc_q;
        16'h000C: rdata = status;
        default:  rdata = 32'h0;
      endcase
    end
  end

  assign bus.ReadData  = rdata;
  assign bus.leds      = leds_q;
  assign bus.out_data  = buf_q[head_q];
  assign bus.out_valid = ~empty;
endmodule

// File: doc/riscv_dmem_mmio.md
# riscv_dmem_mmio

Data-memory stage consuming the pipelined core's memory-stage outputs (MemWrite, ALUResult as address, WriteData) and producing ReadData. Word-addressed RAM plus a small memory-mapped I/O page: LED register, free-running cycle counter, and an 8-bit output byte FIFO drained by a valid/ready stream port. Reads are combinational, so the core's single-cycle memory-stage timing is preserved; all state updates occur on the rising clock edge.

## Interface
- RAM_WORDS, 256: RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..128.
- LED_W, 8: LED register width, 1..32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  write strobe for the current access.
- ALUResult  in  32  byte address; bits [1:0] ignored.
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from address and current state.
- leds  out  LED_W  LED register.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  sink accepts out_data this cycle.

## Operation
- Decode: ALUResult[31:16]==16'hFFFF selects MMIO; otherwise RAM.
  - RAM index is ALUResult[log2(RAM_WORDS)+1:2]; higher bits ignored, so addresses alias.
- RAM: asynchronous read, synchronous write when MemWrite is high.
  - Contents are not cleared by reset.
- MMIO map, using offsets ALUResult[15:0]:
  - 0x0000 LED:
    - Write loads WriteData[LED_W-1:0].
    - Read returns zero-extended leds.
  - 0x0004 CYCLE:
    - Read returns the counter.
    - Write loads WriteData; that cycle's increment is suppressed.
  - 0x0008 TXDATA:
    - Write pushes WriteData[7:0].
    - Read returns 0.
  - 0x000C STATUS:
    - Read returns {16'b0, count[7:0], 5'b0, ovf, full, empty}.
    - Write, any data, clears ovf.
  - Any other MMIO offset: read returns 0; write is ignored.
- Cycle counter: 32-bit, increments every clock, wraps 0xFFFFFFFF→0.
- FIFO: circular buffer with head and tail pointers plus an explicit count (0..FIFO_DEPTH).
  - pop = out_valid & out_ready.
  - push = MemWrite at TXDATA.
  - Push accepted if count<FIFO_DEPTH, or if full with a simultaneous pop.
  - Push while full without a pop is dropped and sets sticky ovf.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - If a STATUS-write clear and an overflow occur in the same cycle, ovf ends set.
- out_data = buffer[head]; its value while out_valid=0 is don't-care but must not be X after reset (buffer reset to 0).

## Timing
- Reset values, applied asynchronously on reset low:
  - leds=0, counter=0, count=0, pointers=0, ovf=0.
  - Consequently out_valid=0, out_data=0.
- ReadData is valid in the same cycle the address is applied (zero latency).
  - Loads after a store to the same address in a later cycle see the new data.
  - A same-cycle load/store returns the old data.
- Write effects are visible from the cycle after the edge:
  - LED, counter load, and FIFO push take effect on that edge.
  - out_valid rises the cycle after the first push.
- A pop takes effect on the edge where out_valid & out_ready.
  - out_valid/out_data may change only after an edge.
  - The sink must not rely on out_data being held after acceptance.
- A read of CYCLE in cycle N returns the value held during cycle N (N cycles since reset release, if never written).
- Reset asserted mid-stream:
  - FIFO empties immediately and out_valid drops asynchronously.
  - Pending data is lost.
  - RAM is untouched.

## Test plan
- Reset, then store 0xDEADBEEF to 0x00000010 and load 0x00000010 and 0x00000410 (RAM_WORDS=256) -> both return 0xDEADBEEF (alias); loading 0x00000014 returns the previously written value, not affected.
- Write 0x1A5 to 0xFFFF0000 -> leds=0xA5 (LED_W=8) next cycle; read returns 0x000000A5; assert reset low -> leds=0 without waiting for clk.
- Read 0xFFFF0004 at cycles 5 and 9 after reset release -> values differ by exactly 4; write 0xFFFFFFFE -> subsequent reads show 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on consecutive cycles.
- out_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> STATUS=0x00000406 (count 4, full, ovf); raise out_ready -> out_data sequence 0x11,0x22,0x33,0x44 then out_valid=0; STATUS write -> STATUS=0x00000001.
- FIFO full, out_ready=1, and push 0x66 in the same cycle -> accepted, count stays 4, ovf stays 0; 0x66 is emitted last.
- Fill FIFO with two bytes, assert reset low mid-drain -> out_valid=0 immediately; after release STATUS=0x00000001.
